// File: rtl/line_memory.sv
`default_nettype none
// ============================================================================
// Module   : line_memory
// Purpose  : Behavioural 256-bit line memory behind the data cache, with a
//            fixed request-to-ack latency modelled by a small FSM and counter.
// Revision : 1.0 - initial release
// ============================================================================
module line_memory #(
    parameter int LATENCY = 10,
    parameter int DEPTH   = 512
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         enable_i,
    input  logic         write_i,
    input  logic [31:0]  addr_i,
    input  logic [255:0] data_i,
    output logic         ack_o,
    output logic [255:0] data_o
);
    localparam int c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    logic [255:0] mem [DEPTH];

    state_t               state_q, state_d;
    logic [c_CNT_W-1:0]   cnt_q, cnt_d;
    logic [c_IDX_W-1:0]   idx_q, idx_d;
    logic                 write_q, write_d;
    logic [255:0]         wdata_q, wdata_d;
    logic                 ack_q, ack_d;
    logic [255:0]         rdata_q, rdata_d;
    logic                 w_mem_we;

    // Offset bits and address bits above the index are don't-care.
    logic w_unused;
    assign w_unused = ^{addr_i[4:0], addr_i[31:5+c_IDX_W]};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        write_d  = write_q;
        wdata_d  = wdata_q;
        ack_d    = 1'b0;
        rdata_d  = rdata_q;
        w_mem_we = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (enable_i) begin
                    idx_d   = addr_i[5 +: c_IDX_W];
                    write_d = write_i;
                    wdata_d = data_i;
                    cnt_d   = c_CNT_LOAD;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = S_ACK;
                    ack_d   = 1'b1;
                    if (write_q) begin
                        w_mem_we = 1'b1;
                    end else begin
                        rdata_d = mem[idx_q];
                    end
                end else begin
                    cnt_d = cnt_q - c_CNT_W'(1);
                end
            end
            // The edge leaving ACK never accepts, which gives the LATENCY+2 issue period.
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            ack_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
        end
    end

    // Array is never cleared; a reset on the completing edge drops the write.
    always_ff @(posedge clk_i) begin
        if (w_mem_we && !rst_i) begin
            mem[idx_q] <= wdata_q;
        end
    end

    assign ack_o  = ack_q;
    assign data_o = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_line_memory.sv
`default_nettype none
// ============================================================================
// Module   : tb_line_memory
// Purpose  : Randomized scoreboard bench for line_memory against a
//            line-array reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_line_memory;
    localparam int LATENCY = 10;
    localparam int DEPTH   = 512;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en  = 1'b0;
    logic         wr  = 1'b0;
    logic [31:0]  addr = '0;
    logic [255:0] din  = '0;
    logic         ack;
    logic [255:0] dout;

    line_memory #(.LATENCY(LATENCY), .DEPTH(DEPTH)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .enable_i (en),
        .write_i  (wr),
        .addr_i   (addr),
        .data_i   (din),
        .ack_o    (ack),
        .data_o   (dout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [255:0] data;
        int           ack_cyc;
    } exp_t;

    exp_t         q[$];
    logic [255:0] ref_mem [int];
    bit           vld [16];
    logic [255:0] last_rd = '0;
    int           cyc = 0;
    bit           rst_prev = 1'b0;
    int           total = 0;
    int           bad = 0;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_prev <= rst;
    end

    function automatic int idx_of(input logic [31:0] a);
        return int'((a >> 5) % DEPTH);
    endfunction

    // Monitor: outputs after a reset edge must be cleared; every ack pops one expectation.
    always @(negedge clk) begin
        if (rst_prev) begin
            total += 2;
            if (ack !== 1'b0) begin
                bad++;
                $display("FAIL reset_ack: ack_o=%b required 0", ack);
            end
            if (dout !== '0) begin
                bad++;
                $display("FAIL reset_data: data_o=%h required 0", dout);
            end
        end else if (ack === 1'b1) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_ack: ack_o=1 at cycle %0d, required no ack", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                total += 2;
                if (cyc != e.ack_cyc) begin
                    bad++;
                    $display("FAIL ack_time: ack at cycle %0d, required %0d", cyc, e.ack_cyc);
                end
                if (dout !== e.data) begin
                    bad++;
                    $display("FAIL ack_data: data_o=%h required %h", dout, e.data);
                end
            end
        end
    end

    // Called at a negedge; b2b means the next edge is the ignored ACK edge.
    task automatic issue(input bit w, input logic [31:0] a, input logic [255:0] d,
                         input bit b2b, input bit track, output int e0);
        en   = 1'b1;
        wr   = w;
        addr = a;
        din  = d;
        if (b2b) @(posedge clk);
        @(posedge clk);
        #1;
        e0 = cyc;
        if (track) begin
            exp_t e;
            int   ix;
            ix = idx_of(a);
            e.ack_cyc = e0 + LATENCY;
            if (w) begin
                ref_mem[ix] = d;
                if (ix < 16) vld[ix] = 1'b1;
            end else begin
                last_rd = ref_mem[ix];
            end
            e.data = last_rd;
            q.push_back(e);
        end
    endtask

    task automatic wait_ack(input bit junk);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < LATENCY + 4 && !seen; k++) begin
            @(negedge clk);
            if (ack === 1'b1) begin
                seen = 1'b1;
            end else if (junk) begin
                en   = 1'($urandom_range(0, 1));
                wr   = 1'($urandom_range(0, 1));
                addr = $urandom;
                din  = {8{$urandom}};
            end
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL ack_timeout: ack_o=0 for %0d cycles, required 1", LATENCY + 4);
        end
    endtask

    task automatic idle(input int n);
        en = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int e0a, e0b, e0;

        // Reset held two cycles with a request pending; accepted on first free edge.
        rst = 1'b1; en = 1'b1; wr = 1'b1; addr = 32'h60; din = {32{8'hA5}};
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        issue(1'b1, 32'h60, {32{8'hA5}}, 1'b0, 1'b1, e0);
        total++;
        if (e0 != 3) begin
            bad++;
            $display("FAIL first_accept: accepted at cycle %0d, required 3", e0);
        end
        wait_ack(1'b0);
        idle(2);

        issue(1'b0, 32'h60, '0, 1'b0, 1'b1, e0);
        wait_ack(1'b0);
        idle(1);

        // Write-back followed immediately by a fill of the same line.
        issue(1'b1, 32'h400, 256'h1234, 1'b0, 1'b1, e0a);
        wait_ack(1'b0);
        issue(1'b0, 32'h400, '0, 1'b1, 1'b1, e0b);
        total++;
        if (e0b - e0a != LATENCY + 2) begin
            bad++;
            $display("FAIL b2b_period: second accept after %0d cycles, required %0d", e0b - e0a, LATENCY + 2);
        end
        wait_ack(1'b0);
        idle(1);

        // Index wrap and ignored offset bits.
        issue(1'b1, 32'h40, {64{4'hC}}, 1'b0, 1'b1, e0);
        wait_ack(1'b0);
        issue(1'b1, 32'h0000_4020, 256'h7, 1'b1, 1'b1, e0);
        wait_ack(1'b0);
        issue(1'b0, 32'h3F, '0, 1'b1, 1'b1, e0);
        wait_ack(1'b0);
        idle(1);

        // Inputs changed and enable dropped while busy.
        issue(1'b0, 32'h20, '0, 1'b0, 1'b1, e0);
        repeat (3) @(negedge clk);
        addr = 32'h40;
        en   = 1'b0;
        wait_ack(1'b0);
        idle(1);

        // Reset in the middle of a write must leave the line untouched.
        issue(1'b1, 32'hA0, 256'h55, 1'b0, 1'b1, e0);
        wait_ack(1'b0);
        idle(1);
        issue(1'b1, 32'hA0, 256'hFF, 1'b0, 1'b0, e0);
        en = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        last_rd = '0;
        issue(1'b0, 32'hA0, '0, 1'b0, 1'b1, e0);
        wait_ack(1'b0);

        // Randomized traffic with noisy inputs during busy periods.
        for (int i = 0; i < 40; i++) begin
            bit          w, b2b;
            int          line;
            logic [31:0] a;
            w    = 1'($urandom_range(0, 1));
            line = $urandom_range(0, 15);
            if (!vld[line]) w = 1'b1;
            a    = ($urandom & 32'hFFFF_C01F) | (32'(line) << 5);
            b2b  = 1'($urandom_range(0, 1));
            if (!b2b) idle($urandom_range(1, 3));
            issue(w, a, {8{$urandom}}, b2b, 1'b1, e0);
            wait_ack(1'b1);
        end
        idle(5);

        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL pending_acks: %0d outstanding, required 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
